// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential 10-bit binary to 3-digit BCD converter (double dabble, one bit per cycle)
// Define BIN2BCD_SAT_EN to clamp results above 999 to 12'h999 and raise ovf.
module bin_to_bcd_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  bin,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [11:0] bcd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        ovf
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state_q, state_d;
   logic [15:0] scratch_q, scratch_d;
   logic [9:0]  operand_q, operand_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;
   logic [11:0] bcd_q, bcd_d;
   logic        ovf_q, ovf_d;

   logic [15:0] adj;
   logic [25:0] shifted;

   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < 4; i++) begin
         if (scratch_q[i*4 +: 4] >= 4'd5)
            adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
      end
      shifted = {adj, operand_q} << 1;
   end

   always_comb begin
      state_d     = state_q;
      scratch_d   = scratch_q;
      operand_d   = operand_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      bcd_d       = bcd_q;
      ovf_d       = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               operand_d  = bin;
               scratch_d  = 16'h0000;
               cnt_d      = 4'd0;
               in_ready_d = 1'b0;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            scratch_d = shifted[25:10];
            operand_d = shifted[9:0];
            cnt_d     = cnt_q + 4'd1;
            if (cnt_q == 4'd9) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
`ifdef BIN2BCD_SAT_EN
               // Thousands digit is never exposed; nonzero means the value exceeded 999.
               if (shifted[25:22] != 4'd0) begin
                  bcd_d = 12'h999;
                  ovf_d = 1'b1;
               end else begin
                  bcd_d = shifted[21:10];
                  ovf_d = 1'b0;
               end
`else
               bcd_d = shifted[21:10];
               ovf_d = 1'b0;
`endif
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         scratch_q   <= 16'h0000;
         operand_q   <= 10'd0;
         cnt_q       <= 4'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         bcd_q       <= 12'h000;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         scratch_q   <= scratch_d;
         operand_q   <= operand_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         bcd_q       <= bcd_d;
         ovf_q       <= ovf_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign bcd       = bcd_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq against an arithmetic reference model
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  bin;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] bcd;
   logic        out_valid;
   logic        out_ready;
   logic        ovf;

   int n_checks = 0;
   int n_pass   = 0;

   bin_to_bcd_seq dut (
      .clk       (clk),
      .rst       (rst),
      .bin       (bin),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bcd       (bcd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [11:0] ref_bcd(input int v);
      int r;
      r = v;
      if (v > 999) begin
`ifdef BIN2BCD_SAT_EN
         r = 999;
`else
         r = v % 1000;
`endif
      end
      return {4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
   endfunction

   function automatic logic ref_ovf(input int v);
`ifdef BIN2BCD_SAT_EN
      return v > 999;
`else
      return (v < 0);
`endif
   endfunction

   function automatic logic digits_ok(input logic [11:0] b);
      return (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic convert(input logic [9:0] v, input bit noise);
      int lat;
      check("pre_in_ready", in_ready, 1);
      bin      = v;
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      bin      = 10'($urandom);
      lat      = 0;
      while (!out_valid && lat < 20) begin
         if (noise) begin
            in_valid = 1'($urandom % 2);
            bin      = 10'($urandom);
         end
         step;
         lat++;
      end
      in_valid = 1'b0;
      check("latency", lat, 10);
      check("bcd", bcd, ref_bcd(int'(v)));
      check("ovf", ovf, ref_ovf(int'(v)));
      check("digits", digits_ok(bcd), 1);
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
      check("out_valid_drop", out_valid, 0);
      check("in_ready_back", in_ready, 1);
   endtask

   initial begin
      logic [11:0] q_exp[$];
      logic [11:0] e;
      int lat, last, got;

      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bin = 10'd0;
      step;
      step;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_bcd", bcd, 12'h000);
      check("rst_ovf", ovf, 0);
      rst = 1'b1;

      convert(10'd0, 1'b0);
      convert(10'd9, 1'b0);
      check("bin9_bcd", bcd, 12'h009);
      convert(10'd255, 1'b0);
      check("bin255_bcd", bcd, 12'h255);
      convert(10'd999, 1'b0);
      check("bin999_ovf", ovf, 0);
      convert(10'd1023, 1'b0);
`ifdef BIN2BCD_SAT_EN
      check("bin1023_bcd", bcd, 12'h999);
      check("bin1023_ovf", ovf, 1);
`else
      check("bin1023_bcd", bcd, 12'h023);
      check("bin1023_ovf", ovf, 0);
`endif

      // Stall in DONE while a competing operand is offered
      bin = 10'd618; in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin step; lat++; end
      check("stall_latency", lat, 10);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'(k % 2 == 0);
         bin      = 10'd77;
         step;
         check("stall_out_valid", out_valid, 1);
         check("stall_bcd", bcd, 12'h618);
         check("stall_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
      check("stall_release_valid", out_valid, 0);
      check("stall_release_ready", in_ready, 1);

      // Reset in the middle of a conversion
      bin = 10'd512; in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      step; step; step;
      rst = 1'b0;
      step;
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_bcd", bcd, 12'h000);
      check("midrst_ovf", ovf, 0);
      rst = 1'b1;
      convert(10'd42, 1'b0);
      check("after_rst_bcd", bcd, 12'h042);

      for (int i = 0; i < 1024; i++)
         convert(10'(i), (i % 3) == 0);

      // Back-to-back: handshakes held high, operand changes every cycle
      out_ready = 1'b1;
      in_valid  = 1'b1;
      last = -1;
      got  = 0;
      for (int cyc = 0; cyc < 150; cyc++) begin
         if (out_valid) begin
            if (q_exp.size() > 0) begin
               e = q_exp.pop_front();
               check("b2b_bcd", bcd, e);
            end else begin
               check("b2b_unexpected", 1, 0);
            end
            check("b2b_digits", digits_ok(bcd), 1);
            if (last >= 0) check("b2b_period", cyc - last, 12);
            last = cyc;
            got++;
         end
         bin = 10'($urandom);
         if (in_ready) q_exp.push_back(ref_bcd(int'(bin)));
         step;
      end
      check("b2b_count", got >= 10, 1);
      in_valid  = 1'b0;
      out_ready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
